// File: rtl/cpu_run_controller.sv
// cpu_run_controller: owns the CPU's enable and reset, providing free-run, single-step
// and breakpoint-halt execution, with a debounced board switch that toggles run/halt.
module cpu_run_controller #(
  parameter int PC_WIDTH          = 8,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int RESET_HOLD_CYCLES = 2
) (
  input  logic                clock,
  input  logic                isResetN,
  input  logic                switch,
  input  logic                runRequest,
  input  logic                stepRequest,
  input  logic                haltRequest,
  input  logic                resetRequest,
  input  logic                breakpointEnable,
  input  logic [PC_WIDTH-1:0] breakpointAddress,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                cpuEnable,
  output logic                cpuReset,
  output logic                isHalted,
  output logic                breakpointHit,
  output logic [1:0]          state
);
  typedef enum logic [1:0] {RESET_HOLD = 2'd0, HALT = 2'd1, RUN = 2'd2, STEP = 2'd3} state_t;
  state_t     r_state;
  logic       r_sync1, r_sync2, r_deb, r_skip, r_hit;
  logic [7:0] r_dcnt;
  logic [3:0] r_hold;
  logic       w_mismatch, w_toggle, w_any_req, w_sw_cmd, w_bp_match;
  assign w_mismatch = r_sync2 != r_deb;
  assign w_toggle   = w_mismatch && r_dcnt == 8'(DEBOUNCE_CYCLES - 1);
  assign w_any_req  = resetRequest | haltRequest | stepRequest | runRequest;
  // an explicit command in the same cycle swallows the switch toggle
  assign w_sw_cmd   = w_toggle & ~w_any_req;
  assign w_bp_match = r_state == RUN && breakpointEnable && pc == breakpointAddress && !r_skip;
  assign cpuEnable     = r_state == STEP || (r_state == RUN && !w_bp_match);
  assign cpuReset      = r_state == RESET_HOLD;
  assign isHalted      = r_state == HALT;
  assign breakpointHit = r_hit;
  assign state         = r_state;
  always_ff @(posedge clock or negedge isResetN)
    if (!isResetN) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_dcnt  <= 8'd0;
    end else begin
      r_sync1 <= switch;
      r_sync2 <= r_sync1;
      r_dcnt  <= (w_mismatch && !w_toggle) ? r_dcnt + 8'd1 : 8'd0;
      if (w_toggle) r_deb <= r_sync2;
    end
  always_ff @(posedge clock or negedge isResetN)
    if (!isResetN) begin
      r_state <= RESET_HOLD;
      r_hold  <= 4'd0;
      r_skip  <= 1'b0;
      r_hit   <= 1'b0;
    end else if (resetRequest) begin
      r_state <= RESET_HOLD;
      r_hold  <= 4'd0;
      r_hit   <= 1'b0;
    end else begin
      case (r_state)
        RESET_HOLD: begin
          r_hold <= r_hold + 4'd1;
          if (r_hold == 4'(RESET_HOLD_CYCLES - 1)) r_state <= HALT;
        end
        HALT:
          if (!haltRequest && (stepRequest || runRequest || w_sw_cmd)) begin
            r_state <= stepRequest ? STEP : RUN;
            r_skip  <= 1'b1;
            r_hit   <= 1'b0;
          end
        RUN: begin
          r_skip <= 1'b0;
          if (w_bp_match) begin
            r_state <= HALT;
            r_hit   <= 1'b1;
          end else if (haltRequest || w_sw_cmd) r_state <= HALT;
        end
        default: r_state <= HALT;
      endcase
    end
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed scenarios plus random commands, checked every cycle
// against a behavioural model of the run controller and a simple incrementing-pc CPU.
module tb_cpu_run_controller;
  localparam int DB = 4;
  localparam int RH = 2;
  logic clock = 0, isResetN = 0, switch = 0;
  logic runRequest = 0, stepRequest = 0, haltRequest = 0, resetRequest = 0, breakpointEnable = 0;
  logic [7:0] breakpointAddress = 0, pc = 0;
  logic cpuEnable, cpuReset, isHalted, breakpointHit;
  logic [1:0] state;
  int n_tests = 0, n_fail = 0;

  cpu_run_controller #(.PC_WIDTH(8), .DEBOUNCE_CYCLES(DB), .RESET_HOLD_CYCLES(RH)) dut (
    .clock(clock), .isResetN(isResetN), .switch(switch), .runRequest(runRequest),
    .stepRequest(stepRequest), .haltRequest(haltRequest), .resetRequest(resetRequest),
    .breakpointEnable(breakpointEnable), .breakpointAddress(breakpointAddress), .pc(pc),
    .cpuEnable(cpuEnable), .cpuReset(cpuReset), .isHalted(isHalted),
    .breakpointHit(breakpointHit), .state(state));

  always #5 clock = ~clock;

  // the CPU under control: pc clears while held in reset, advances when enabled
  always @(posedge clock) pc <= cpuReset ? 8'd0 : pc + 8'(cpuEnable);

  task automatic chk(input string n, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // model: mode 0 reset-hold, 1 halt, 2 run, 3 step; rem = hold cycles still to go;
  // hist = raw switch value seen at each recent clock edge, newest last
  int m_st = 0, m_rem = RH;
  bit m_skip = 0, m_hit = 0, m_deb = 0;
  bit hist[$];

  function automatic bit m_bp();
    return m_st == 2 && breakpointEnable && pc == breakpointAddress && !m_skip;
  endfunction

  always @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      m_st = 0; m_rem = RH; m_skip = 0; m_hit = 0; m_deb = 0;
      hist = {};
      repeat (DB + 1) hist.push_back(1'b0);
    end else begin
      bit tog, etog, bp, req;
      tog = 1;
      // switch accepted once it has differed from the debounced level for DB edges, after 2 sync stages
      for (int k = 0; k < DB; k++) if (hist[hist.size() - 2 - k] == m_deb) tog = 0;
      if (tog) m_deb = !m_deb;
      req  = resetRequest | haltRequest | stepRequest | runRequest;
      etog = tog && !req;
      bp   = m_bp();
      if (resetRequest) begin
        m_st = 0; m_rem = RH; m_hit = 0;
      end else if (m_st == 0) begin
        if (m_rem == 1) m_st = 1; else m_rem--;
      end else if (m_st == 1) begin
        if (haltRequest) ;
        else if (stepRequest) begin m_st = 3; m_skip = 1; m_hit = 0; end
        else if (runRequest || etog) begin m_st = 2; m_skip = 1; m_hit = 0; end
      end else if (m_st == 2) begin
        m_skip = 0;
        if (bp) begin m_st = 1; m_hit = 1; end
        else if (haltRequest || etog) m_st = 1;
      end else m_st = 1;
      hist.push_back(switch);
      if (hist.size() > DB + 2) void'(hist.pop_front());
    end
  end

  always @(negedge clock) begin
    chk("state", int'(state), m_st);
    chk("cpuEnable", int'(cpuEnable), int'(m_st == 3 || (m_st == 2 && !m_bp())));
    chk("cpuReset", int'(cpuReset), int'(m_st == 0));
    chk("isHalted", int'(isHalted), int'(m_st == 1));
    chk("breakpointHit", int'(breakpointHit), int'(m_hit));
  end

  initial begin
    bit seen;
    tick();
    chk("por_state", int'(state), 0);
    chk("por_cpuReset", int'(cpuReset), 1);
    isResetN = 1;
    chk("hold0_cpuReset", int'(cpuReset), 1);
    tick();
    chk("hold1_cpuReset", int'(cpuReset), 1);
    chk("hold1_en", int'(cpuEnable), 0);
    tick();
    chk("hold_done_state", int'(state), 1);
    chk("hold_done_halted", int'(isHalted), 1);
    chk("hold_done_cpuReset", int'(cpuReset), 0);
    for (int i = 1; i <= 3; i++) begin
      stepRequest = 1; tick(); stepRequest = 0;
      chk("step_state", int'(state), 3);
      chk("step_en", int'(cpuEnable), 1);
      tick();
      chk("step_pc", int'(pc), i);
      chk("step_back_halt", int'(state), 1);
      chk("step_en_off", int'(cpuEnable), 0);
    end
    resetRequest = 1; tick(); resetRequest = 0;
    chk("rreq_state", int'(state), 0);
    tick(); tick();
    chk("rreq_halt", int'(state), 1);
    chk("rreq_pc", int'(pc), 0);
    breakpointEnable = 1; breakpointAddress = 8'd5;
    runRequest = 1; tick(); runRequest = 0;
    chk("run_state", int'(state), 2);
    seen = 0;
    for (int i = 0; i < 20 && state != 2'd1; i++) begin
      if (pc == 8'd5 && !seen) begin chk("bp_en_drop", int'(cpuEnable), 0); seen = 1; end
      tick();
    end
    chk("bp_seen", int'(seen), 1);
    chk("bp_halt", int'(state), 1);
    chk("bp_hit", int'(breakpointHit), 1);
    chk("bp_pc", int'(pc), 5);
    runRequest = 1; tick(); runRequest = 0;
    chk("resume_hit_clr", int'(breakpointHit), 0);
    chk("resume_en", int'(cpuEnable), 1);
    tick();
    chk("resume_pc", int'(pc), 6);
    chk("resume_state", int'(state), 2);
    haltRequest = 1; tick(); haltRequest = 0;
    breakpointEnable = 0;
    chk("halt_state", int'(state), 1);
    chk("halt_en", int'(cpuEnable), 0);
    runRequest = 1; tick(); runRequest = 0;
    repeat (3) begin chk("freerun_en", int'(cpuEnable), 1); tick(); end
    haltRequest = 1; tick(); haltRequest = 0;
    chk("halt2_state", int'(state), 1);
    switch = 1; tick(); switch = 0;
    repeat (8) tick();
    chk("glitch1", int'(state), 1);
    switch = 1; repeat (3) tick(); switch = 0;
    repeat (8) tick();
    chk("glitch3", int'(state), 1);
    switch = 1;
    repeat (5) tick();
    chk("sw_before", int'(state), 1);
    tick();
    chk("sw_run_at6", int'(state), 2);
    switch = 0;
    repeat (5) tick();
    chk("sw_still_run", int'(state), 2);
    tick();
    chk("sw_halt_at6", int'(state), 1);
    runRequest = 1; tick(); runRequest = 0;
    tick();
    resetRequest = 1; stepRequest = 1; tick(); resetRequest = 0; stepRequest = 0;
    chk("rs_state", int'(state), 0);
    chk("rs_cpuReset", int'(cpuReset), 1);
    tick();
    chk("rs_cpuReset2", int'(cpuReset), 1);
    tick();
    chk("rs_halt", int'(state), 1);
    chk("rs_hit", int'(breakpointHit), 0);
    runRequest = 1; tick(); runRequest = 0;
    chk("ar_pre_en", int'(cpuEnable), 1);
    #1 isResetN = 0;
    #1;
    chk("ar_en", int'(cpuEnable), 0);
    chk("ar_cpuReset", int'(cpuReset), 1);
    tick(); isResetN = 1;
    tick(); tick();
    chk("ar_halt", int'(state), 1);
    for (int c = 0; c < 4000; c++) begin
      runRequest   = ($urandom % 20) == 0;
      stepRequest  = ($urandom % 25) == 0;
      haltRequest  = ($urandom % 30) == 0;
      resetRequest = ($urandom % 150) == 0;
      if (($urandom % 8) == 0) switch = ~switch;
      if (($urandom % 20) == 0) breakpointEnable = $urandom_range(0, 1);
      if (($urandom % 10) == 0) breakpointAddress = pc + 8'($urandom_range(0, 6));
      if (!isResetN) isResetN = 1;
      else if (($urandom % 600) == 0) isResetN = 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences the CPU core: owns its enable and reset, giving free-running, single-step and breakpoint-halt execution.
- Takes the raw board `switch` plus pulse commands from the debug/host side.
- Drives `cpuEnable` and `cpuReset` into the CPU and watches the CPU's `pc` output for a breakpoint match.
- Sits between the board I/O / debug logic and the CPU instance in top.

Parameters:
- PC_WIDTH, 8, width of pc and breakpointAddress; must match the CPU's PC_WIDTH.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a switch change is accepted; range 1..255.
- RESET_HOLD_CYCLES, 2, cycles cpuReset is held high after controller reset or a reset request; range 1..15.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- isResetN  in  1  asynchronous, active-low reset.
- switch  in  1  raw, unsynchronised board switch; each accepted level change toggles run/halt.
- runRequest  in  1  one-cycle pulse: start free-running.
- stepRequest  in  1  one-cycle pulse: execute exactly one CPU cycle.
- haltRequest  in  1  one-cycle pulse: stop.
- resetRequest  in  1  one-cycle pulse: re-reset the CPU, then go to HALT.
- breakpointEnable  in  1  arms the breakpoint compare.
- breakpointAddress  in  PC_WIDTH  pc value at which RUN stops.
- pc  in  PC_WIDTH  current CPU program counter.
- cpuEnable  out  1  CPU advances one cycle on each clock where this is high.
- cpuReset  out  1  active-high synchronous reset to the CPU.
- isHalted  out  1  high in HALT state.
- breakpointHit  out  1  sticky flag: RUN stopped on a breakpoint.
- state  out  2  encoded FSM state: 0 RESET_HOLD, 1 HALT, 2 RUN, 3 STEP.

Behaviour:
Reset:
- isResetN low → state=RESET_HOLD, hold counter=0, cpuEnable=0, cpuReset=1, isHalted=0, breakpointHit=0, skipBreak=0.
- Synchroniser and debounced switch value load 0; debounce counter=0.

Switch path:
- 2-flop synchroniser feeds the debouncer.
- When the synchronised value ≠ the debounced value for DEBOUNCE_CYCLES consecutive cycles, the debounced value updates.
- Any mismatch-free cycle clears the counter.
- Each debounced change (either direction) raises a one-cycle switchToggle.
- Latency from raw edge to switchToggle: 2 + DEBOUNCE_CYCLES cycles.

FSM, evaluated each rising edge. Command priority: resetRequest > haltRequest > stepRequest > runRequest.
- RESET_HOLD:
  - cpuReset=1, cpuEnable=0.
  - Count RESET_HOLD_CYCLES cycles, then → HALT.
  - All other requests are ignored.
- HALT:
  - cpuEnable=0, isHalted=1.
  - runRequest or switchToggle → RUN; stepRequest → STEP.
  - Either transition sets skipBreak=1 and clears breakpointHit.
- RUN:
  - bpMatch = breakpointEnable & (pc == breakpointAddress) & ~skipBreak.
  - cpuEnable = ~bpMatch (combinational, so the breakpoint instruction does not execute).
  - bpMatch → HALT and set breakpointHit.
  - haltRequest or switchToggle → HALT, breakpointHit unchanged.
  - skipBreak clears after the first RUN cycle, so resuming from a breakpoint advances past it.
- STEP:
  - cpuEnable=1 for exactly one cycle, breakpoint ignored, then → HALT.
  - A haltRequest in the same cycle still lets the step complete.
- resetRequest in any state → RESET_HOLD, hold counter=0, breakpointHit cleared.

Boundary cases:
- Simultaneous switchToggle and request: the request wins; switchToggle is dropped.
- Requests arriving in RESET_HOLD are dropped, not queued.
- isResetN assertion mid-RUN forces cpuEnable=0 and cpuReset=1 immediately (asynchronous).
- A breakpoint at pc=0 right after reset stops on the first RUN cycle only if skipBreak=0. Entering RUN always sets skipBreak, so pc 0 executes once.
- breakpointAddress changes take effect the same cycle (combinational compare).

Test Plan:
- Reset release, RESET_HOLD_CYCLES=2: cpuReset high for cycles 0–1; state=1 (HALT), isHalted=1 at cycle 2; cpuEnable=0 throughout.
- runRequest pulse in HALT: next cycle state=2 and cpuEnable=1 continuously; haltRequest → state=1, cpuEnable=0 the cycle after.
- stepRequest ×3 with a CPU model incrementing pc: cpuEnable high exactly one cycle per request; pc goes 0→1→2→3; state returns to 1 each time.
- Raw switch toggled, including 1-cycle glitches, DEBOUNCE_CYCLES=4: glitches cause no transition; a stable edge yields RUN exactly 6 cycles after the edge; a second stable edge yields HALT.
- breakpointEnable=1, breakpointAddress=5, RUN from pc=0: cpuEnable drops in the cycle pc==5; state=1, breakpointHit=1; next runRequest clears breakpointHit and pc advances to 6.
- resetRequest during RUN with simultaneous stepRequest: reset wins; cpuReset=1 for 2 cycles, then HALT with breakpointHit=0.
